fft_bitrev_loader: RTL and testbench
====================================

FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 SHALL have parameter N, default 8, FFT size in points; legal values are powers of two from 4 to 64.
REQ-002 SHALL have parameter W, default 16, sample component width in bits (signed two's complement).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream sample present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts a sample this cycle.
REQ-007 SHALL have port in_r, input, W bits signed, sample real part.
REQ-008 SHALL have port in_i, input, W bits signed, sample imaginary part.
REQ-009 SHALL have port flush, input, 1 bit, discard any partially collected frame.
REQ-010 SHALL have port frame_valid, output, 1 bit, complete bit-reversed frame on xr/xi.
REQ-011 SHALL have port frame_ready, input, 1 bit, downstream stage-0 consumer takes the frame.
REQ-012 SHALL have port xr, output, N x W bits signed, frame real parts in bit-reversed order, element k in bits [k*W +: W].
REQ-013 SHALL have port xi, output, N x W bits signed, frame imaginary parts, same packing as xr.
REQ-014 SHALL have port frame_count, output, 8 bits, number of frames handed off, modulo 256.

Function
REQ-015 SHALL implement two states: FILL (collecting samples) and FULL (holding a complete frame).
REQ-016 SHALL drive in_ready = 1 in FILL and 0 in FULL; frame_valid = 1 in FULL and 0 in FILL.
REQ-017 SHALL count a sample as accepted only on a cycle with in_valid = 1 and in_ready = 1.
REQ-018 SHALL write the accepted sample at index wr_idx into buffer slot bitrev(wr_idx) over log2(N) bits, then increment wr_idx.
REQ-019 SHALL, on acceptance of the sample at wr_idx = N-1, enter FULL on the next cycle with wr_idx = 0; frame_valid rises one cycle after the Nth acceptance.
REQ-020 SHALL, in FULL, hold xr/xi stable and ignore in_valid, in_r and in_i.
REQ-021 SHALL, in FULL with frame_ready = 1, return to FILL on the next cycle and increment frame_count, wrapping 255 -> 0.
REQ-022 SHALL NOT require frame_ready to be low while frame_valid is low; frame_ready has no effect in FILL.
REQ-023 SHALL, on flush = 1 in FILL, set wr_idx to 0 and discard any sample offered in the same cycle; flush takes priority over acceptance.
REQ-024 SHALL ignore flush in FULL; a completed frame is always delivered.
REQ-025 SHALL drive xr/xi directly from the buffer registers with no combinational path from any input to any output.
REQ-026 SHALL retain the previous frame's buffer contents in slots not yet overwritten during FILL; these contents are don't-care while frame_valid = 0.
REQ-027 SHALL sustain at most one frame per N+1 cycles, because in_ready is low for at least one cycle per frame.

Reset
REQ-028 SHALL, while rst = 1, force state FILL, wr_idx = 0, frame_count = 0, in_ready = 1 and frame_valid = 0 at the next clock edge.
REQ-029 SHALL clear all buffer slots, and therefore xr and xi, to 0 on reset.
REQ-030 SHALL, on reset asserted mid-fill or in FULL, drop the partial or held frame without incrementing frame_count; rst overrides flush and all handshakes.

Structure
REQ-031 SHALL take the sample width constant (16) and the bit-reverse index function from the shared package fft_pkg, which the FFT stage modules also use.
REQ-032 SHALL contain no sub-modules; the bit-reversal is a package function, not a separate instance.

Verification
REQ-033 SHALL cover basic frame: after reset, drive 8 consecutive samples k = 0..7 with in_r = 100*k and in_i = -k -> frame_valid = 1 one cycle after the 8th acceptance, with xr = {0,400,200,600,100,500,300,700} and xi = {0,-4,-2,-6,-1,-5,-3,-7} (element 0 first).
REQ-034 SHALL cover backpressure: hold frame_ready = 0 for 5 cycles in FULL while in_valid = 1 -> in_ready = 0, xr/xi unchanged, frame_count unchanged; release -> FILL next cycle, frame_count = 1.
REQ-035 SHALL cover gapped input: toggle in_valid every other cycle -> same frame as REQ-033, frame_valid rises one cycle after the 8th accepted sample.
REQ-036 SHALL cover flush: after 3 accepted samples, pulse flush together with in_valid, then send 8 new samples -> first frame contains only the 8 new samples.
REQ-037 SHALL cover mid-operation reset: assert rst after 5 samples and again in FULL -> frame_valid = 0, in_ready = 1, frame_count = 0, xr = xi = 0.
REQ-038 SHALL cover counter wrap: complete 256 frames back-to-back -> frame_count reads 0, and 1 after the 257th frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, loader FSM states and the bit-reverse
// index helper used by the input loader and the butterfly stages.
package fft_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int MAX_LOG2N = 6;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } ldr_state_e;

  // Reverses the low nbits of idx; the loop bound is fixed so it unrolls for synthesis.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = idx;
    for (int unsigned b = 0; b < MAX_LOG2N; b++) begin
      if (b < nbits) begin
        r = (r << 1) | (v & 32'd1);
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_loader.sv
// Collects N complex samples into a frame buffer in bit-reversed order and hands
// the complete frame to FFT stage 0 with a valid/ready handshake.
module fft_bitrev_loader
  import fft_pkg::*;
#(
  parameter int N = 8,
  parameter int W = SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_r,
  input  logic signed [W-1:0] in_i,
  input  logic                flush,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [N*W-1:0]      xr,
  output logic [N*W-1:0]      xi,
  output logic [7:0]          frame_count
);

  localparam int LOGN = $clog2(N);

  ldr_state_e        state_q, state_d;
  logic [LOGN-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic [N*W-1:0]    xr_q, xi_q;
  logic              wr_en;
  logic [LOGN-1:0]   wr_slot;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    in_ready      = 1'b0;
    frame_valid   = 1'b0;
    wr_slot       = LOGN'(bitrev(32'(wr_idx_q), LOGN));

    unique case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        // Flush wins over a sample offered in the same cycle.
        if (flush) begin
          wr_idx_d = '0;
        end else if (in_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LOGN'(N - 1)) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        frame_valid = 1'b1;
        if (frame_ready) begin
          state_d       = ST_FILL;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      wr_idx_q      <= '0;
      frame_count_q <= '0;
      xr_q          <= '0;
      xi_q          <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      frame_count_q <= frame_count_d;
      for (int unsigned k = 0; k < N; k++) begin
        if (wr_en && (wr_slot == LOGN'(k))) begin
          xr_q[k*W +: W] <= in_r;
          xi_q[k*W +: W] <= in_i;
        end
      end
    end
  end

  assign xr          = xr_q;
  assign xi          = xi_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader: a reference model predicts each frame
// into a scoreboard queue, compared when the DUT raises frame_valid.
module tb_fft_bitrev_loader;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int LOGN = $clog2(N);
  localparam int FW   = N * W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_r = '0;
  logic signed [W-1:0] in_i = '0;
  logic                flush = 1'b0;
  logic                frame_valid;
  logic                frame_ready = 1'b0;
  logic [FW-1:0]       xr;
  logic [FW-1:0]       xi;
  logic [7:0]          frame_count;

  int checks = 0;
  int errors = 0;

  int            mdl_idx = 0;
  logic          mdl_full = 1'b0;
  logic [7:0]    exp_cnt = '0;
  logic [FW-1:0] mbuf_r = '0;
  logic [FW-1:0] mbuf_i = '0;
  logic [FW-1:0] held_r = '0;
  logic [FW-1:0] held_i = '0;
  logic [FW-1:0] q_r[$];
  logic [FW-1:0] q_i[$];

  fft_bitrev_loader #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_r        (in_r),
    .in_i        (in_i),
    .flush       (flush),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .xr          (xr),
    .xi          (xi),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic int brev(input int v);
    int r;
    int t;
    r = 0;
    t = v;
    for (int b = 0; b < LOGN; b++) begin
      r = (r << 1) | (t & 1);
      t = t >> 1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    rst      = 1'b0;
    mdl_idx  = 0;
    mdl_full = 1'b0;
    exp_cnt  = '0;
    mbuf_r   = '0;
    mbuf_i   = '0;
    q_r.delete();
    q_i.delete();
    chk("rst_frame_valid", FW'(frame_valid), FW'(1'b0));
    chk("rst_in_ready", FW'(in_ready), FW'(1'b1));
    chk("rst_frame_count", FW'(frame_count), FW'(8'd0));
    chk("rst_xr", xr, '0);
    chk("rst_xi", xi, '0);
  endtask

  // One clock of stimulus; the model decides acceptance/handoff from its own state.
  task automatic drive(input logic v, input int r, input int i, input logic fl);
    logic acc, hand, done, fv_before;
    int   slot;
    in_valid  = v;
    in_r      = W'(r);
    in_i      = W'(i);
    flush     = fl;
    fv_before = frame_valid;
    acc       = v && !mdl_full && !fl;
    hand      = mdl_full && frame_ready;
    done      = 1'b0;
    if (!mdl_full && fl) mdl_idx = 0;
    if (acc) begin
      slot = brev(mdl_idx);
      mbuf_r[slot*W +: W] = W'(r);
      mbuf_i[slot*W +: W] = W'(i);
      mdl_idx++;
      if (mdl_idx == N) begin
        mdl_idx = 0;
        done    = 1'b1;
        q_r.push_back(mbuf_r);
        q_i.push_back(mbuf_i);
      end
    end
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    if (hand) begin
      mdl_full = 1'b0;
      exp_cnt  = exp_cnt + 8'd1;
    end
    if (done) mdl_full = 1'b1;
    chk("in_ready", FW'(in_ready), FW'(!mdl_full));
    chk("frame_valid", FW'(frame_valid), FW'(mdl_full));
    chk("frame_count", FW'(frame_count), FW'(exp_cnt));
    if (frame_valid && !fv_before) begin
      chk("frame_expected", FW'(q_r.size() != 0), FW'(1'b1));
      if (q_r.size() != 0) begin
        held_r = q_r.pop_front();
        held_i = q_i.pop_front();
        chk("frame_xr", xr, held_r);
        chk("frame_xi", xi, held_i);
      end
    end else if (frame_valid && fv_before) begin
      chk("hold_xr", xr, held_r);
      chk("hold_xi", xi, held_i);
    end
  endtask

  initial begin
    int            tab_r[N];
    int            tab_i[N];
    logic [FW-1:0] vr;
    logic [FW-1:0] vi;

    tab_r = '{0, 400, 200, 600, 100, 500, 300, 700};
    tab_i = '{0, -4, -2, -6, -1, -5, -3, -7};

    do_reset();

    // Basic frame, then compare against the literal bit-reversed table.
    for (int k = 0; k < N; k++) drive(1'b1, 100 * k, -k, 1'b0);
    vr = '0;
    vi = '0;
    for (int k = 0; k < N; k++) begin
      vr[k*W +: W] = W'(tab_r[k]);
      vi[k*W +: W] = W'(tab_i[k]);
    end
    chk("basic_xr_table", xr, vr);
    chk("basic_xi_table", xi, vi);

    // Backpressure: held frame with junk offered on the input.
    frame_ready = 1'b0;
    for (int c = 0; c < 5; c++) drive(1'b1, 77, 77, 1'b0);
    frame_ready = 1'b1;
    drive(1'b1, 55, 55, 1'b0);
    chk("bp_count_one", FW'(frame_count), FW'(8'd1));

    // Gapped input.
    frame_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 100 * k, -k, 1'b0);
      drive(1'b0, 9999, 9999, 1'b0);
    end
    chk("gap_xr_table", xr, vr);
    chk("gap_xi_table", xi, vi);
    frame_ready = 1'b1;
    drive(1'b0, 0, 0, 1'b0);

    // Flush after three samples, with a sample offered alongside it.
    frame_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b1, 1000 + k, -1000 - k, 1'b0);
    drive(1'b1, 5555, 5555, 1'b1);
    for (int k = 0; k < N; k++) drive(1'b1, 2000 + k, -2000 - k, 1'b0);
    frame_ready = 1'b1;
    drive(1'b0, 0, 0, 1'b0);

    // Reset mid-fill and again while holding a full frame.
    frame_ready = 1'b0;
    for (int k = 0; k < 5; k++) drive(1'b1, 300 + k, 300 + k, 1'b0);
    do_reset();
    for (int k = 0; k < N; k++) drive(1'b1, 400 + k, -400 - k, 1'b0);
    do_reset();

    // Counter wrap over 257 back-to-back frames.
    frame_ready = 1'b1;
    for (int f = 0; f < 257; f++) begin
      for (int k = 0; k < N; k++) drive(1'b1, f * N + k, -(f * N + k), 1'b0);
      drive(1'b1, 0, 0, 1'b0);
      if (f == 255) chk("wrap_zero", FW'(frame_count), FW'(8'd0));
    end
    chk("wrap_one", FW'(frame_count), FW'(8'd1));
    chk("queue_empty", FW'(q_r.size()), FW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
